usb_tx_sequencer: RTL and testbench

USB_TX_SEQUENCER -- requirements
Module: usb_tx_sequencer

---
 rtl/usb_tx_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_usb_tx_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_sequencer.sv
// USB transmit sequencer: serialises SYNC, PID, payload bytes and an optional CRC16 phase into the bit stuffer.
// Optional feature: define TX_CRC16_EN to insert the 16-advance CRC16 phase after the last data byte.
module usb_tx_sequencer (
    input  logic       gclk,
    input  logic       reset_l,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    input  logic       halt_tx_shift,
    output logic       stuff_din,
    output logic       start_bit_stuff,
    output logic       cs1_l,
    output logic       shift_tx_crc16,
    output logic       eop_req,
    output logic       busy,
    output logic       tx_err
);

    typedef enum logic [2:0] {IDLE, CLR, SYNC, PID, DATA, CRC, EOP, ERR} state_t;

    state_t     state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] data_sr_reg, data_sr_next;
    logic       last_reg, last_next;
    logic       pid_only_reg, pid_only_next;
    logic [2:0] cyc_cnt_reg, cyc_cnt_next;
    logic       tx_err_reg, tx_err_next;
    logic       ready_en_reg;
    logic       advance;
    logic       byte_end;
`ifdef TX_CRC16_EN
    logic [3:0] crc_cnt_reg, crc_cnt_next;
`endif

    // ready_en_reg keeps tx_ready low until the first edge after reset release
    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= 3'd0;
            data_sr_reg  <= 8'd0;
            last_reg     <= 1'b0;
            pid_only_reg <= 1'b0;
            cyc_cnt_reg  <= 3'd0;
            tx_err_reg   <= 1'b0;
            ready_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            data_sr_reg  <= data_sr_next;
            last_reg     <= last_next;
            pid_only_reg <= pid_only_next;
            cyc_cnt_reg  <= cyc_cnt_next;
            tx_err_reg   <= tx_err_next;
            ready_en_reg <= 1'b1;
        end
    end

`ifdef TX_CRC16_EN
    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            crc_cnt_reg <= 4'd0;
        end else begin
            crc_cnt_reg <= crc_cnt_next;
        end
    end
`endif

    assign advance  = ((state_reg == SYNC) || (state_reg == PID) ||
                       (state_reg == DATA) || (state_reg == CRC)) && !halt_tx_shift;
    assign byte_end = advance && (bit_cnt_reg == 3'd7);
    assign busy     = (state_reg != IDLE);
    assign tx_err   = tx_err_reg;

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        data_sr_next    = data_sr_reg;
        last_next       = last_reg;
        pid_only_next   = pid_only_reg;
        cyc_cnt_next    = cyc_cnt_reg;
        tx_err_next     = 1'b0;
        tx_ready        = 1'b0;
        stuff_din       = 1'b0;
        start_bit_stuff = 1'b0;
        cs1_l           = 1'b1;
        shift_tx_crc16  = 1'b0;
        eop_req         = 1'b0;
`ifdef TX_CRC16_EN
        crc_cnt_next    = crc_cnt_reg;
`endif

        if (advance && (state_reg != CRC)) begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
        end
        if (advance && ((state_reg == PID) || (state_reg == DATA))) begin
            data_sr_next = {1'b0, data_sr_reg[7:1]};
        end

        case (state_reg)
            IDLE: begin
                tx_ready = ready_en_reg;
                if (tx_valid && ready_en_reg) begin
                    data_sr_next  = tx_data;
                    pid_only_next = tx_last;
                    bit_cnt_next  = 3'd0;
                    state_next    = CLR;
                end
            end
            CLR: begin
                cs1_l      = 1'b0;
                state_next = SYNC;
            end
            SYNC: begin
                start_bit_stuff = 1'b1;
                stuff_din       = (bit_cnt_reg == 3'd7);
                if (byte_end) begin
                    state_next = PID;
                end
            end
            PID: begin
                start_bit_stuff = 1'b1;
                stuff_din       = data_sr_reg[0];
                tx_ready        = (bit_cnt_reg == 3'd7) && !pid_only_reg;
                if (byte_end && pid_only_reg) begin
                    cyc_cnt_next = 3'd0;
                    state_next   = EOP;
                end
            end
            DATA: begin
                start_bit_stuff = 1'b1;
                stuff_din       = data_sr_reg[0];
                tx_ready        = (bit_cnt_reg == 3'd7) && !last_reg;
                if (byte_end && last_reg) begin
`ifdef TX_CRC16_EN
                    crc_cnt_next = 4'd0;
                    state_next   = CRC;
`else
                    cyc_cnt_next = 3'd0;
                    state_next   = EOP;
`endif
                end
            end
`ifdef TX_CRC16_EN
            CRC: begin
                start_bit_stuff = 1'b1;
                shift_tx_crc16  = 1'b1;
                if (advance) begin
                    crc_cnt_next = crc_cnt_reg + 4'd1;
                    if (crc_cnt_reg == 4'd15) begin
                        cyc_cnt_next = 3'd0;
                        state_next   = EOP;
                    end
                end
            end
`endif
            EOP: begin
                eop_req      = 1'b1;
                cyc_cnt_next = cyc_cnt_reg + 3'd1;
                if (cyc_cnt_reg == 3'd2) begin
                    cyc_cnt_next = 3'd0;
                    state_next   = IDLE;
                end
            end
            ERR: begin
                stuff_din    = 1'b1;
                cyc_cnt_next = cyc_cnt_reg + 3'd1;
                if (cyc_cnt_reg == 3'd7) begin
                    cyc_cnt_next = 3'd0;
                    state_next   = EOP;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Byte fetch: the handshake only counts on the edge that shifts out bit 7
        if (byte_end && tx_ready) begin
            if (tx_valid) begin
                data_sr_next = tx_data;
                last_next    = tx_last;
                state_next   = DATA;
            end else begin
                tx_err_next  = 1'b1;
                cyc_cnt_next = 3'd0;
                state_next   = ERR;
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Randomised self-checking bench for usb_tx_sequencer; the reference model builds a per-cycle stimulus
// and expected-output timeline for a whole packet directly from the protocol rules.
module tb_usb_tx_sequencer;

`ifdef TX_CRC16_EN
    localparam int CRC_BITS = 16;
`else
    localparam int CRC_BITS = 0;
`endif

    logic       gclk = 1'b0;
    logic       reset_l;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       halt_tx_shift;
    logic       stuff_din;
    logic       start_bit_stuff;
    logic       cs1_l;
    logic       shift_tx_crc16;
    logic       eop_req;
    logic       busy;
    logic       tx_err;

    usb_tx_sequencer dut (
        .gclk            (gclk),
        .reset_l         (reset_l),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .tx_last         (tx_last),
        .tx_ready        (tx_ready),
        .halt_tx_shift   (halt_tx_shift),
        .stuff_din       (stuff_din),
        .start_bit_stuff (start_bit_stuff),
        .cs1_l           (cs1_l),
        .shift_tx_crc16  (shift_tx_crc16),
        .eop_req         (eop_req),
        .busy            (busy),
        .tx_err          (tx_err)
    );

    always #5 gclk = ~gclk;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic       halt;
    } stim_t;

    stim_t      stim_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] byte_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         pkt_no = 0;

    // Output vector order: {tx_ready, stuff_din, start_bit_stuff, cs1_l, shift_tx_crc16, eop_req, busy, tx_err}
    function automatic logic [7:0] mk_out(bit rdy, bit din, bit stf, bit cs1, bit crc, bit eop, bit bsy, bit err);
        return {rdy, din, stf, cs1, crc, eop, bsy, err};
    endfunction

    function automatic stim_t mk_stim(logic v, logic [7:0] d, logic l, logic h);
        stim_t s;
        s.valid = v;
        s.data  = d;
        s.last  = l;
        s.halt  = h;
        return s;
    endfunction

    function automatic bit rnd_halt(int pct);
        return (pct > 0) && (int'($urandom_range(99)) < pct);
    endfunction

    // Handshake qualifiers outside a fetch point must be ignored, so drive noise there
    function automatic stim_t junk(bit h);
        return mk_stim(1'(($urandom & 1)), 8'($urandom), 1'(($urandom & 1)), h);
    endfunction

    function automatic logic [7:0] obs_vec();
        return {tx_ready, stuff_din, start_bit_stuff, cs1_l, shift_tx_crc16, eop_req, busy, tx_err};
    endfunction

    task automatic push(input stim_t s, input logic [7:0] e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b (rdy,din,stf,cs1_l,crc,eop,busy,err)", tag, obs, exp_v);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference timeline for the packet in byte_q (byte 0 = PID). underrun_at = index of the byte
    // whose fetch sees tx_valid=0 (-1 for none); forced_pos = stream bit position halted once.
    task automatic build(input int underrun_at, input int halt_pct, input int forced_pos);
        int         n, pos, bi, crc;
        bit         err, fetch, h, forced_done, b;
        logic [7:0] cur;
        n = byte_q.size();
        push(mk_stim(1'b1, byte_q[0], n == 1, 1'b0), mk_out(1, 0, 0, 1, 0, 0, 0, 0));
        push(junk(rnd_halt(halt_pct)), mk_out(0, 0, 0, 0, 0, 0, 1, 0));
        pos = 0;
        err = 0;
        forced_done = 0;
        while (pos < 8 * (n + 1) && !err) begin
            bi    = pos / 8 - 1;
            fetch = (pos % 8 == 7) && (bi >= 0) && (bi < n - 1);
            if (bi < 0) begin
                b = (pos % 8 == 7);
            end else begin
                cur = byte_q[bi];
                b   = cur[pos % 8];
            end
            h = rnd_halt(halt_pct) || (pos == forced_pos && !forced_done);
            if (pos == forced_pos && h) forced_done = 1;
            if (fetch)
                push(mk_stim(bi + 1 != underrun_at, byte_q[bi + 1], bi + 1 == n - 1, h),
                     mk_out(1, b, 1, 1, 0, 0, 1, 0));
            else
                push(junk(h), mk_out(0, b, 1, 1, 0, 0, 1, 0));
            if (!h) begin
                if (fetch && bi + 1 == underrun_at) err = 1;
                pos++;
            end
        end
        if (err) begin
            for (int i = 0; i < 8; i++)
                push(junk(rnd_halt(halt_pct)), mk_out(0, 1, 0, 1, 0, 0, 1, i == 0));
        end else begin
            crc = 0;
            while (crc < CRC_BITS) begin
                h = rnd_halt(halt_pct);
                push(junk(h), mk_out(0, 0, 1, 1, 1, 0, 1, 0));
                if (!h) crc++;
            end
        end
        for (int i = 0; i < 3; i++)
            push(junk(rnd_halt(halt_pct)), mk_out(0, 0, 0, 1, 0, 1, 1, 0));
        for (int i = 0; i < 2; i++)
            push(mk_stim(1'b0, 8'($urandom), 1'(($urandom & 1)), rnd_halt(halt_pct)), mk_out(1, 0, 0, 1, 0, 0, 0, 0));
    endtask

    task automatic replay(input int limit, output int busy_cycles);
        stim_t      s;
        logic [7:0] e;
        busy_cycles = 0;
        for (int i = 0; i < limit && stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            @(posedge gclk);
            #1;
            tx_valid      = s.valid;
            tx_data       = s.data;
            tx_last       = s.last;
            halt_tx_shift = s.halt;
            @(negedge gclk);
            if (busy) busy_cycles++;
            check($sformatf("pkt%0d_cyc%0d", pkt_no, i), obs_vec(), e);
        end
    endtask

    task automatic run_packet(input int underrun_at, input int halt_pct, input int forced_pos, output int busy_cycles);
        build(underrun_at, halt_pct, forced_pos);
        replay(1 << 30, busy_cycles);
        $display("pkt %0d: pid=%02h bytes=%0d underrun_at=%0d halt_pct=%0d busy=%0d",
                 pkt_no, byte_q[0], byte_q.size(), underrun_at, halt_pct, busy_cycles);
        pkt_no++;
    endtask

    localparam logic [7:0] RST_VEC  = 8'b0001_0000;
    localparam logic [7:0] IDLE_VEC = 8'b1001_0000;

    initial begin
        int bc, n, ua;
        reset_l       = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        tx_last       = 1'b0;
        halt_tx_shift = 1'b0;
        #2;
        check("reset_outputs", obs_vec(), RST_VEC);
        repeat (2) @(negedge gclk);
        reset_l = 1'b1;
        #1;
        check("ready_low_before_edge", obs_vec(), RST_VEC);
        @(negedge gclk);
        check("ready_after_first_edge", obs_vec(), IDLE_VEC);

        // PID-only handshake packet
        byte_q = '{8'hD2};
        run_packet(-1, 0, -1, bc);
        check_int("busy_pid_only", bc, 1 + 8 + 8 + 3);

        // PID + two data bytes, no halts
        byte_q = '{8'hC3, 8'hFF, 8'h00};
        run_packet(-1, 0, -1, bc);
        check_int("busy_two_bytes", bc, 1 + 8 + 8 + 16 + CRC_BITS + 3);

        // Same packet, one halt after six 1s of 0xFF
        byte_q = '{8'hC3, 8'hFF, 8'h00};
        run_packet(-1, 0, 22, bc);
        check_int("busy_one_halt", bc, 1 + 8 + 8 + 16 + CRC_BITS + 3 + 1);

        // Underrun at a DATA fetch point
        byte_q = '{8'hC3, 8'h5A, 8'hA5};
        run_packet(2, 0, -1, bc);
        check_int("busy_underrun", bc, 1 + 8 + 8 + 8 + 8 + 3);

        // Reset mid-packet (inside CRC when present, else inside DATA)
        byte_q = '{8'hC3, 8'hFF, 8'h00};
        build(-1, 0, -1);
        replay((CRC_BITS > 0) ? 39 : 22, bc);
        stim_q.delete();
        exp_q.delete();
        #2;
        reset_l       = 1'b0;
        tx_valid      = 1'b0;
        halt_tx_shift = 1'b0;
        #1;
        check("midpkt_reset_outputs", obs_vec(), RST_VEC);
        @(posedge gclk);
        #1;
        check("midpkt_reset_held", obs_vec(), RST_VEC);
        @(negedge gclk);
        reset_l = 1'b1;
        #1;
        check("midpkt_ready_low", obs_vec(), RST_VEC);
        @(negedge gclk);
        check("midpkt_ready_high", obs_vec(), IDLE_VEC);
        pkt_no++;
        byte_q = '{8'h4B, 8'h96};
        run_packet(-1, 0, -1, bc);

        // Randomised packets with halts and occasional underruns
        for (int p = 0; p < 14; p++) begin
            n = 1 + int'($urandom_range(4));
            byte_q.delete();
            for (int k = 0; k < n; k++) byte_q.push_back(8'($urandom));
            ua = (n >= 2 && $urandom_range(3) == 0) ? int'($urandom_range(n - 1, 1)) : -1;
            run_packet(ua, (p % 3) * 15, -1, bc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
